// File: rtl/axis_mem_arbiter_pkg.sv
// Shared types and default widths for the packet-level AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BEATS_DEF = 256;

    // Widths for the default configuration; parameterised instances derive their own.
    localparam int GRANT_W = $clog2(NUM_REQ_DEF);
    localparam int CNT_W   = $clog2(MAX_BEATS_DEF) + 1;

endpackage

// File: rtl/axis_mem_arbiter_if.sv
// AXI-Stream bundle carrying N packed lanes; N=1 for the single memory-side stream.
interface axis_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 1
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*STRB_W-1:0]     tstrb;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tlast;
    logic [N-1:0]            tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GW      = GRANT_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [GW-1:0]      pick,
    output logic               any
);

    int idx;

    // Scan from last+1 upward; the last grant is checked last so it has lowest priority.
    always_comb begin
        pick = last;
        any  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                pick = GW'(idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_mem_arbiter.sv
// Packet-level round-robin arbiter feeding the memory controller write stream.
// A grant is held from first beat to tlast; a beat-count watchdog forces tlast
// on runaway packets and raises a sticky error.
//
// state     | meaning
// ARB_IDLE  | no grant held, outputs quiet, picking next requester
// ARB_GRANT | granted requester passed straight through to m01
module axis_mem_arbiter
    import axis_arb_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REQ    = NUM_REQ_DEF,
    parameter int  MAX_BEATS  = MAX_BEATS_DEF,
    localparam int GW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BEATS) + 1,
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                axis_aclk,
    input  logic                axis_aresetn,
    axis_mem_arbiter_if.slave   s_axis,
    axis_mem_arbiter_if.master  m01_axis,
    output logic [GW-1:0]       grant_id,
    output logic                busy,
    output logic                pkt_trunc_err
);

    arb_state_t    state;
    logic [CW-1:0] beat_cnt;
    logic [GW-1:0] pick;
    logic          pick_any;
    logic          wd_hit;
    logic          out_valid;
    logic          out_last;
    logic          beat_acc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req  (s_axis.tvalid),
        .last (grant_id),
        .pick (pick),
        .any  (pick_any)
    );

    assign wd_hit = (beat_cnt == CW'(MAX_BEATS - 1));

    // Pass-through mux: granted requester drives m01, everything else quiet.
    always_comb begin
        out_valid      = 1'b0;
        out_last       = 1'b0;
        m01_axis.tdata = '0;
        m01_axis.tstrb = '0;
        s_axis.tready  = '0;
        if (state == ARB_GRANT) begin
            out_valid               = s_axis.tvalid[grant_id];
            out_last                = s_axis.tlast[grant_id] | wd_hit;
            m01_axis.tdata          = s_axis.tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            m01_axis.tstrb          = s_axis.tstrb[grant_id*SW +: SW];
            s_axis.tready[grant_id] = m01_axis.tready[0];
        end
    end

    assign m01_axis.tvalid = out_valid;
    assign m01_axis.tlast  = out_last;
    assign beat_acc        = out_valid & m01_axis.tready[0];

    // Grant FSM with beat counter, watchdog error flag and registered busy.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= ARB_IDLE;
            grant_id      <= GW'(NUM_REQ - 1);
            busy          <= 1'b0;
            beat_cnt      <= '0;
            pkt_trunc_err <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (out_last) begin
                            busy  <= 1'b0;
                            state <= ARB_IDLE;
                            // Forced tlast without the requester's own tlast: remainder re-arbitrates.
                            if (wd_hit && !s_axis.tlast[grant_id]) begin
                                pkt_trunc_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mem_arbiter.sv
// Directed bench for axis_mem_arbiter with a per-requester scoreboard.
module tb_axis_mem_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       trunc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur = -1;
    int last_end = -1;
    bit in_pkt = 1'b0;

    beat_t src_q[NR][$];
    beat_t exp_q[NR][$];
    int    exp_grant[$];
    logic [NR-1:0] pop_mask = '0;
    beat_t drv_b;
    beat_t mon_b;
    bit    bp_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    axis_mem_arbiter_if #(.DATA_WIDTH(DW), .N(NR)) s_if ();
    axis_mem_arbiter_if #(.DATA_WIDTH(DW), .N(1))  m_if ();

    axis_mem_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BEATS  (MB)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis        (s_if),
        .m01_axis      (m_if),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_trunc_err (trunc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic bit drained();
        bit d = (exp_grant.size() == 0);
        for (int i = 0; i < NR; i++) if (exp_q[i].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic push_src(input int r, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b = '{data: d, strb: s, last: l};
        src_q[r].push_back(b);
    endtask

    task automatic push_exp(input int r, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        beat_t b;
        b = '{data: d, strb: s, last: l};
        exp_q[r].push_back(b);
    endtask

    // Packet whose output is expected unchanged (tlast on final beat, strobes varied).
    task automatic push_pkt(input int r, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            push_src(r, base + DW'(k), (k % 2 == 0) ? 4'hF : 4'h3, k == n - 1);
            push_exp(r, base + DW'(k), (k % 2 == 0) ? 4'hF : 4'h3, k == n - 1);
        end
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            @(posedge clk);
            n++;
        end
        total++;
        assert (drained()) else begin
            bad++;
            $error("FAIL %s_drain observed=pending expected=drained", tag);
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        @(posedge clk); #2;
        while (busy !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check(tag, 64'(busy), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Requester sources: present queue head, retire it after a handshake seen at negedge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (!rst_n) src_q[i].delete();
            else if (pop_mask[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_q[i].size() > 0) begin
                drv_b = src_q[i][0];
                s_if.tvalid[i]          = 1'b1;
                s_if.tdata[i*DW +: DW]  = drv_b.data;
                s_if.tstrb[i*SW +: SW]  = drv_b.strb;
                s_if.tlast[i]           = drv_b.last;
            end else begin
                s_if.tvalid[i]          = 1'b0;
                s_if.tdata[i*DW +: DW]  = '0;
                s_if.tstrb[i*SW +: SW]  = '0;
                s_if.tlast[i]           = 1'b0;
            end
        end
    end

    // Output monitor: grant order, beat contents, one-cycle bubble between packets.
    always @(negedge clk) begin
        if (!rst_n) begin
            pop_mask = '0;
            in_pkt   = 1'b0;
            last_end = -1;
            exp_grant.delete();
            for (int i = 0; i < NR; i++) exp_q[i].delete();
        end else begin
            pop_mask = s_if.tvalid & s_if.tready;
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                if (!in_pkt) begin
                    in_pkt = 1'b1;
                    total++;
                    assert (exp_grant.size() > 0) else begin
                        bad++;
                        $error("FAIL grant_unexpected observed=%0d expected=none", grant_id);
                    end
                    if (exp_grant.size() > 0) begin
                        cur = exp_grant.pop_front();
                        check("grant_order", 64'(grant_id), 64'(cur));
                        if (last_end >= 0) check("bubble_gap", 64'(cyc - last_end), 64'd2);
                    end else begin
                        cur = -1;
                    end
                end
                if (cur >= 0) begin
                    total++;
                    assert (exp_q[cur].size() > 0) else begin
                        bad++;
                        $error("FAIL extra_beat observed=0x%0h expected=none", m_if.tdata);
                    end
                    if (exp_q[cur].size() > 0) begin
                        mon_b = exp_q[cur].pop_front();
                        check("beat", {27'd0, m_if.tdata, m_if.tstrb, m_if.tlast},
                              {27'd0, mon_b.data, mon_b.strb, mon_b.last});
                    end
                end
                if (m_if.tlast[0]) begin
                    in_pkt   = 1'b0;
                    last_end = cyc;
                end
            end
        end
    end

    initial begin
        m_if.tready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state",
              {18'd0, busy, trunc, grant_id, m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tstrb, s_if.tready},
              {18'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0});
        #1 rst_n = 1'b1;

        // Single requester, 3-beat packet.
        @(posedge clk); #3;
        push_src(1, 32'hA1, 4'hF, 1'b0); push_exp(1, 32'hA1, 4'hF, 1'b0);
        push_src(1, 32'hA2, 4'hF, 1'b0); push_exp(1, 32'hA2, 4'hF, 1'b0);
        push_src(1, 32'hA3, 4'hF, 1'b1); push_exp(1, 32'hA3, 4'hF, 1'b1);
        exp_grant.push_back(1);
        @(posedge clk); #2;
        check("single_not_yet_busy", 64'(busy), 64'd0);
        check("idle_outputs_zero", {27'd0, m_if.tvalid, m_if.tdata, s_if.tready}, 64'd0);
        @(posedge clk); #2;
        check("single_busy", 64'(busy), 64'd1);
        check("single_grant_id", 64'(grant_id), 64'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("single_last_beat", {62'd0, busy, m_if.tlast}, {62'd0, 1'b1, 1'b1});
        @(posedge clk); #2;
        check("single_busy_drop", 64'(busy), 64'd0);
        wait_drained("single", 20);

        // Fairness: everyone streams two 2-beat packets.
        do_reset();
        @(posedge clk); #3;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NR; r++) begin
                push_pkt(r, 2, 32'h1000_0000 + DW'(r * 256 + p * 16));
            end
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < NR; r++) exp_grant.push_back(r);
        wait_drained("fair", 100);

        // Back-pressure during a 4-beat packet from req2.
        do_reset();
        @(posedge clk); #3;
        push_pkt(2, 4, 32'hB000_0000);
        exp_grant.push_back(2);
        wait_busy("bp_busy");
        for (int k = 0; k < 6; k++) begin
            m_if.tready = bp_pat[k];
            #1;
            check("bp_ready_mirror", 64'(s_if.tready), bp_pat[k] ? 64'h4 : 64'h0);
            @(posedge clk); #2;
        end
        m_if.tready = 1'b1;
        wait_drained("bp", 20);
        @(posedge clk); #2;
        check("bp_no_trunc", {62'd0, busy, trunc}, 64'd0);

        // Watchdog: req2 sends 6 beats with no tlast.
        do_reset();
        @(posedge clk); #3;
        for (int k = 0; k < 6; k++) begin
            push_src(2, 32'hC0 + DW'(k), 4'hF, 1'b0);
            push_exp(2, 32'hC0 + DW'(k), 4'hF, k == 3);
        end
        exp_grant.push_back(2);
        exp_grant.push_back(2);
        check("wd_err_clear_before", 64'(trunc), 64'd0);
        wait_drained("wd", 60);
        @(posedge clk); #2;
        check("wd_trunc_err", 64'(trunc), 64'd1);
        check("wd_regrant_held", {62'd0, busy, m_if.tvalid}, {62'd0, 1'b1, 1'b0});
        do_reset();
        #2;
        check("wd_err_reset", {62'd0, busy, trunc}, 64'd0);

        // Contention: req3 arrives while req0 is mid-packet.
        @(posedge clk); #3;
        push_pkt(0, 4, 32'hD000_0000);
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        wait_busy("cont_busy");
        push_pkt(3, 2, 32'hE000_0000);
        for (int k = 0; k < 4; k++) begin
            check("cont_ready_held_off", {58'd0, grant_id, s_if.tready}, {58'd0, 2'd0, 4'b0001});
            @(posedge clk); #2;
        end
        check("cont_bubble", {59'd0, busy, s_if.tready}, 64'd0);
        @(posedge clk); #2;
        check("cont_req3_grant", {61'd0, busy, grant_id}, {61'd0, 1'b1, 2'd3});
        wait_drained("cont", 30);

        // Reset asserted during beat 2 of a req0 packet.
        do_reset();
        @(posedge clk); #3;
        push_pkt(0, 4, 32'hF000_0000);
        exp_grant.push_back(0);
        wait_busy("rst_busy");
        @(posedge clk); #2;
        check("rst_beat2_present", 64'(m_if.tdata), 64'hF000_0001);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear",
              {18'd0, busy, trunc, grant_id, m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tstrb, s_if.tready},
              {18'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #3;
        for (int r = 0; r < NR; r++) push_pkt(r, 1, 32'h5000_0000 + DW'(r));
        for (int r = 0; r < NR; r++) exp_grant.push_back(r);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rst_tie_req0", {61'd0, busy, grant_id}, {61'd0, 1'b1, 2'd0});
        wait_drained("rst_tie", 40);
        @(posedge clk); #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
